// File: rtl/uart_tx_reporter.sv
// 8N1 UART transmitter with a valid/ready byte interface and a registered TX line.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data bit 7 and the stop bit.
module uart_tx_reporter #(
  parameter int CLK_HZ = 12000000,
  parameter int BAUD   = 115200,
  parameter int DIV    = CLK_HZ / BAUD
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic [7:0] DATA,
  input  logic       VALID,
  output logic       READY,
  output logic       BUSY,
  output logic       TX
);

  localparam int BAUD_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(DIV - 1);

  generate
    if (DIV < 2) begin : g_div_check
      $error("uart_tx_reporter: DIV must be at least 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t            state_reg, state_next;
  logic [BAUD_W-1:0] baud_reg, baud_next;
  logic [2:0]        bit_reg, bit_next;
  logic [7:0]        shift_reg, shift_next;
  logic              tx_reg, tx_next;
  logic              parity_reg, parity_next;
  logic              bit_end;

  assign bit_end = (baud_reg == BAUD_LAST);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_reg  <= S_IDLE;
      baud_reg   <= '0;
      bit_reg    <= '0;
      shift_reg  <= '0;
      parity_reg <= 1'b0;
      tx_reg     <= 1'b1;
    end else begin
      state_reg  <= state_next;
      baud_reg   <= baud_next;
      bit_reg    <= bit_next;
      shift_reg  <= shift_next;
      parity_reg <= parity_next;
      tx_reg     <= tx_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    bit_next    = bit_reg;
    shift_next  = shift_reg;
    parity_next = parity_reg;
    // The baud counter free-runs inside a frame and sits at 0 while idle.
    baud_next   = (state_reg == S_IDLE || bit_end) ? '0 : baud_reg + 1'b1;
    case (state_reg)
      S_IDLE: begin
        if (VALID) begin
          state_next  = S_START;
          bit_next    = '0;
          shift_next  = DATA;
          parity_next = ^DATA;
        end
      end
      S_START: begin
        if (bit_end) state_next = S_DATA;
      end
      S_DATA: begin
        if (bit_end) begin
          shift_next = shift_reg >> 1;
          bit_next   = bit_reg + 3'd1;
          if (bit_reg == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_next = S_PARITY;
`else
            state_next = S_STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) state_next = S_STOP;
      end
`endif
      S_STOP: begin
        if (bit_end) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // TX is registered from the upcoming state so the line changes on the same edge as the state.
  always_comb begin
    READY   = (state_reg == S_IDLE);
    BUSY    = (state_reg != S_IDLE);
    tx_next = 1'b1;
    case (state_next)
      S_IDLE:   tx_next = 1'b1;
      S_START:  tx_next = 1'b0;
      S_DATA:   tx_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_next = parity_next;
`endif
      S_STOP:   tx_next = 1'b1;
      default:  tx_next = 1'b1;
    endcase
  end

  assign TX = tx_reg;

endmodule

// File: doc/uart_tx_reporter.md
Name: uart_tx_reporter

Overview:
- UART transmitter, the other direction of the FPGA board's serial link. The top-level wrapper currently loops RX straight back to TX; this block drives TX instead.
- Serialises one byte per valid/ready handshake as 8N1 (8 data bits, LSB first, no parity, 1 stop bit), or 8E1 when parity is compiled in.
- Sits beside the scan-chain wrapper. Its first use is reporting the 8 project outputs to a host terminal.

Parameters:
- CLK_HZ, 12000000, system clock frequency in Hz.
- BAUD, 115200, line rate.
- DIV, CLK_HZ/BAUD (integer, truncated; 104 at defaults), clocks per bit. It must be at least 2; elaboration fails otherwise.

Ports:
- CLK  input  1  system clock, all state on rising edge.
- RESET_N  input  1  asynchronous, active-low reset.
- DATA  input  8  byte to send; sampled only on an accepted handshake.
- VALID  input  1  DATA is available.
- READY  output  1  block can accept a byte this cycle.
- BUSY  output  1  a frame is in progress, start bit through end of stop bit.
- TX  output  1  serial line, idle high, registered output.

Behaviour:
- Reset (asynchronous, RESET_N=0):
  - TX=1, READY=1, BUSY=0.
  - State=IDLE; bit counter, baud counter and shift register cleared.
  - Reset mid-frame aborts the frame immediately and the line goes high with no glitch low.
- States:
  - IDLE: READY=1, TX=1. A handshake is accepted when VALID&&READY are both high on a rising edge. On acceptance: DATA latched into the shift register, next state START, READY=0 and BUSY=1 from the next cycle.
  - START: TX=0 for exactly DIV cycles, then DATA.
  - DATA: TX=shift[0] for DIV cycles per bit, shift right after each bit. After bit 7 the next state is PARITY (if enabled) or STOP.
  - PARITY (only with the option): TX=even parity for DIV cycles, then STOP.
  - STOP: TX=1 for DIV cycles, then IDLE.
- Timing:
  - Latency: TX falls on the first rising edge after acceptance.
  - Frame length: 10*DIV cycles (11*DIV with parity) from TX fall to the return to IDLE.
- Back-to-back transfers:
  - IDLE always lasts at least 1 cycle.
  - If VALID is held high, the next byte is accepted on that first IDLE cycle, so the minimum inter-frame stop time is DIV+1 cycles.
- Handshake rules:
  - VALID may assert or deassert at any time; only a sample where VALID&&READY both hold transfers.
  - DATA changes while not READY are ignored.
  - VALID high during a frame does nothing until READY returns.
- Counters:
  - The baud counter is ceil(log2(DIV)) bits; it counts 0..DIV-1 and wraps to 0 on each bit boundary.
  - The bit counter is 3 bits and wraps 7→0 on the last data bit.
  - The baud counter restarts at 0 on acceptance so that the start bit is exactly DIV cycles.
- Timing paths: no combinational path from VALID or DATA to TX. READY and BUSY are decoded from registered state only.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: an even-parity bit (XOR of the latched 8 data bits) is inserted between bit 7 and stop, giving an 11*DIV frame.
- Undefined: no PARITY state exists and the frame is 10*DIV cycles. All other behaviour is identical.

Test Plan:
- Reset: hold RESET_N=0 for 5 cycles, release → TX=1, READY=1, BUSY=0; TX stays 1 for 2000 cycles with VALID=0.
- Single byte: DATA=8'hA5, VALID pulsed 1 cycle, DIV=104 → sampling at bit centres reads 0 (start), then 1,0,1,0,0,1,0,1, then 1 (stop). READY=0 for 1040 cycles, then returns to 1.
- Back-to-back: VALID held high with DATA=8'h00 then 8'hFF → two frames; the second TX fall occurs exactly 1041 cycles after the first. Sampled bytes are 00 then FF.
- Ignored data: change DATA to 8'h3C mid-frame while sending 8'h55 → line carries 55 unaltered.
- Mid-frame reset: assert RESET_N=0 during data bit 3 of 8'h00 → TX=1 in the same cycle, READY=1 after release, and the next byte 8'h81 is sent cleanly.
- Parity (UART_TX_PARITY_EN): send 8'h07 → parity bit=1; send 8'h03 → parity bit=0. Frame length is 1144 cycles.
